// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared types and width helpers for the CCDFF configuration-chain loader.
//   ccff_ld_state_e : loader FSM states
//   total_cnt_w     : width of a counter that must reach CHAIN_LEN without wrapping
//   word_cnt_w      : width of a counter that must reach WORD_W without wrapping
//   commit_cnt_w    : width of the CFGE pulse timer (counts 0 .. CFGE_CYCLES-1)
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } ccff_ld_state_e;

  function automatic int total_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int word_cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  function automatic int commit_cnt_w(input int cfge_cycles);
    return (cfge_cycles > 1) ? $clog2(cfge_cycles) : 1;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer
//   Holds one bitstream word and presents it LSB-first on the chain head.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data / load_cnt (first bit appears on head next cycle)
//   load_data  : bitstream word
//   load_cnt   : number of bits of this word that will be shifted
//   shift      : advance one bit
//   head       : serial bit for the first CCDFF; holds after the last bit of a word
//   last       : exactly one bit of the current word remains
//   empty      : no bits of the current word remain
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = word_cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              shift,
  output logic              head,
  output logic              last,
  output logic              empty
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_shr;
  logic [CNT_W-1:0]  cnt_q;

  assign sr_shr = sr_q >> 1;
  assign last   = (cnt_q == CNT_W'(1));
  assign empty  = (cnt_q == '0);

  // Word storage: data path, no reset
  always_ff @(posedge clk) begin
    if (load) begin
      sr_q <= load_data;
    end else if (shift) begin
      sr_q <= sr_shr;
    end
  end

  // Bit count and registered head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      head  <= 1'b0;
    end else if (load) begin
      cnt_q <= load_cnt;
      head  <= load_data[0];
    end else if (shift) begin
      cnt_q <= cnt_q - CNT_W'(1);
      // keep the final bit on head through the following LOAD/COMMIT cycles
      if (!last) begin
        head <= sr_shr[0];
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Streams a bitstream into the CCDFF configuration chain, then pulses CFGE.
//   CLK, RESET_B  : clock (shared with the chain), asynchronous active-low reset
//   start         : begin a load (only honoured in IDLE)
//   abort         : cancel the current load, highest priority
//   word_data     : bitstream word, bit 0 shifted first
//   word_valid    : word_data valid
//   word_ready    : loader accepts a word this cycle
//   ccff_head     : serial data to the first CCDFF
//   ccff_shift_en : chain advances one bit per edge while high
//   cfge          : configuration enable to every CCDFF
//   busy          : loader not idle
//   done          : one-cycle pulse after a completed commit
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int CHAIN_LEN   = 1024,
  parameter int CFGE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              cfge,
  output logic              busy,
  output logic              done
);

  localparam int TOT_W = total_cnt_w(CHAIN_LEN);
  localparam int CNT_W = word_cnt_w(WORD_W);
  localparam int TMR_W = commit_cnt_w(CFGE_CYCLES);

  ccff_ld_state_e   state_q;
  ccff_ld_state_e   state_nxt;
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_inc;
  logic [TOT_W-1:0] remain;
  logic [TMR_W-1:0] tmr_q;

  logic             ser_load;
  logic             ser_shift;
  logic             ser_last;
  logic             ser_empty;
  logic [CNT_W-1:0] ser_load_cnt;

  logic             word_ready_nxt;
  logic             shift_en_nxt;
  logic             cfge_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign total_inc = total_q + TOT_W'(1);
  assign remain    = TOT_W'(CHAIN_LEN) - total_q;

  // word_ready mirrors state_q == ST_LOAD, so it doubles as the LOAD qualifier
  assign ser_load  = word_ready && word_valid && !abort;
  assign ser_shift = (state_q == ST_SHIFT) && !ser_empty && !abort;

  // The final word may be partial: shift only the bits still missing from the chain
  always_comb begin
    ser_load_cnt = CNT_W'(WORD_W);
    if (int'(remain) < WORD_W) begin
      ser_load_cnt = CNT_W'(remain);
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .clk       (CLK),
    .rst_n     (RESET_B),
    .load      (ser_load),
    .load_data (word_data),
    .load_cnt  (ser_load_cnt),
    .shift     (ser_shift),
    .head      (ccff_head),
    .last      (ser_last),
    .empty     (ser_empty)
  );

  // State register, total bit counter and commit timer
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_IDLE && start) begin
        total_q <= '0;
      end else if (ser_shift) begin
        total_q <= total_inc;
      end
      tmr_q <= (state_q == ST_COMMIT && state_nxt == ST_COMMIT) ? tmr_q + TMR_W'(1) : '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_nxt = ST_LOAD;
        ST_LOAD:   if (word_valid) state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (total_inc == TOT_W'(CHAIN_LEN)) begin
            state_nxt = ST_COMMIT;
          end else if (ser_last) begin
            state_nxt = ST_LOAD;
          end
        end
        ST_COMMIT: if (tmr_q == TMR_W'(CFGE_CYCLES - 1)) state_nxt = ST_DONE;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    word_ready_nxt = (state_nxt == ST_LOAD);
    shift_en_nxt   = (state_nxt == ST_SHIFT);
    cfge_nxt       = (state_nxt == ST_COMMIT);
    busy_nxt       = (state_nxt != ST_IDLE);
    done_nxt       = (state_nxt == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      word_ready    <= 1'b0;
      ccff_shift_en <= 1'b0;
      cfge          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      word_ready    <= word_ready_nxt;
      ccff_shift_en <= shift_en_nxt;
      cfge          <= cfge_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader
//   Directed bench: one loader with WORD_W=4, CHAIN_LEN=10, CFGE_CYCLES=2 and a
//   second with CHAIN_LEN=8 for the exact-multiple case. Cycle c is the period
//   after posedge c-1; start is presented before edge 0.
module tb_ccff_bitstream_loader;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       start, abort, word_valid;
  logic [3:0] word_data;
  logic       word_ready, ccff_head, ccff_shift_en, cfge, busy, done;

  logic       start8, abort8, valid8;
  logic [3:0] data8;
  logic       rdy8, head8, se8, cfge8, busy8, done8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] c_se, c_rdy, c_cfge, c_done, c_busy, c_headc;
  logic [15:0] c_head;
  int          c_nshift, c_nacc;
  logic [3:0]  words [3];

  always #5 CLK = ~CLK;

  ccff_bitstream_loader #(.WORD_W(4), .CHAIN_LEN(10), .CFGE_CYCLES(2)) u_dut (
    .CLK (CLK), .RESET_B (RESET_B), .start (start), .abort (abort),
    .word_data (word_data), .word_valid (word_valid), .word_ready (word_ready),
    .ccff_head (ccff_head), .ccff_shift_en (ccff_shift_en), .cfge (cfge),
    .busy (busy), .done (done)
  );

  ccff_bitstream_loader #(.WORD_W(4), .CHAIN_LEN(8), .CFGE_CYCLES(2)) u_dut8 (
    .CLK (CLK), .RESET_B (RESET_B), .start (start8), .abort (abort8),
    .word_data (data8), .word_valid (valid8), .word_ready (rdy8),
    .ccff_head (head8), .ccff_shift_en (se8), .cfge (cfge8),
    .busy (busy8), .done (done8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One load on u_dut; per-cycle outputs land in bit c of the capture vectors.
  task automatic run10(input int stall_from, input int stall_len, input int restart_cyc,
                       input int abort_cyc, input int ncyc);
    int   idx;
    logic acc;
    c_se = '0; c_rdy = '0; c_cfge = '0; c_done = '0; c_busy = '0; c_headc = '0;
    c_head = '0; c_nshift = 0; c_nacc = 0;
    idx = 0;
    word_data  = words[0];
    word_valid = 1'b1;
    abort      = 1'b0;
    start      = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      acc = word_ready & word_valid;
      @(posedge CLK); #1;
      start = 1'b0;
      abort = 1'b0;
      if (acc) begin
        c_nacc++;
        if (idx < 2) idx++;
        word_data = words[idx];
      end
      c_se[c]    = ccff_shift_en;
      c_rdy[c]   = word_ready;
      c_cfge[c]  = cfge;
      c_done[c]  = done;
      c_busy[c]  = busy;
      c_headc[c] = ccff_head;
      if (ccff_shift_en) begin
        if (c_nshift < 16) c_head[c_nshift] = ccff_head;
        c_nshift++;
      end
      word_valid = !(c >= stall_from && c < stall_from + stall_len);
      if (c == restart_cyc) start = 1'b1;
      if (c == abort_cyc)   abort = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] s_se8, s_rdy8, s_cfge8, s_done8;
    logic [7:0]  h8;
    int          n8, nacc8;
    logic        acc8;

    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
    RESET_B = 1'b0;
    start = 0; abort = 0; word_valid = 0; word_data = 0;
    start8 = 0; abort8 = 0; valid8 = 0; data8 = 0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outs", {word_ready, ccff_head, ccff_shift_en, cfge, busy, done}, 32'h0);
    check("reset_outs8", {rdy8, head8, se8, cfge8, busy8, done8}, 32'h0);
    RESET_B = 1'b1;
    @(posedge CLK); #1;
    check("idle_outs", {word_ready, ccff_head, ccff_shift_en, cfge, busy, done}, 32'h0);

    // Basic load: words A,5,3
    run10(0, 0, 0, 0, 20);
    check("basic_shift_en", c_se, 32'h000037BC);
    check("basic_ready", c_rdy, 32'h00000842);
    check("basic_cfge", c_cfge, 32'h0000C000);
    check("basic_done", c_done, 32'h00010000);
    check("basic_busy", c_busy, 32'h0001FFFE);
    check("basic_head_seq", {16'h0, c_head}, 32'h0000035A);
    check("basic_nshift", c_nshift, 32'd10);
    check("basic_nacc", c_nacc, 32'd3);
    check("basic_hold_c6", {31'h0, c_headc[6]}, 32'd1);
    check("basic_hold_c11", {31'h0, c_headc[11]}, 32'd0);

    // Source stall: word_valid low in cycles 6..10
    run10(6, 5, 0, 0, 25);
    check("stall_shift_en", c_se, 32'h0006F03C);
    check("stall_ready", c_rdy, 32'h00010FC2);
    check("stall_cfge", c_cfge, 32'h00180000);
    check("stall_done", c_done, 32'h00200000);
    check("stall_busy", c_busy, 32'h003FFFFE);
    check("stall_head_seq", {16'h0, c_head}, 32'h0000035A);
    check("stall_nshift", c_nshift, 32'd10);

    // start pulsed during SHIFT is ignored
    run10(0, 0, 3, 0, 20);
    check("restart_shift_en", c_se, 32'h000037BC);
    check("restart_done", c_done, 32'h00010000);
    check("restart_nshift", c_nshift, 32'd10);
    check("restart_head_seq", {16'h0, c_head}, 32'h0000035A);

    // Abort in cycle 8 (second word's shift)
    run10(0, 0, 0, 8, 20);
    check("abort_shift_en", c_se, 32'h000001BC);
    check("abort_ready", c_rdy, 32'h00000042);
    check("abort_cfge", c_cfge, 32'h0);
    check("abort_done", c_done, 32'h0);
    check("abort_busy", c_busy, 32'h000001FE);

    // Reset pulse during COMMIT (cycle 14)
    run10(0, 0, 0, 0, 14);
    check("pre_rst_cfge_busy", {cfge, busy}, 32'h3);
    #2 RESET_B = 1'b0;
    #1;
    check("rst_async_outs", {word_ready, ccff_shift_en, cfge, busy, done}, 32'h0);
    #2 RESET_B = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("post_rst_idle", {cfge, busy, done}, 32'h0);
    end
    run10(0, 0, 0, 0, 20);
    check("clean_shift_en", c_se, 32'h000037BC);
    check("clean_cfge", c_cfge, 32'h0000C000);
    check("clean_done", c_done, 32'h00010000);
    check("clean_head_seq", {16'h0, c_head}, 32'h0000035A);

    // Exact multiple: CHAIN_LEN=8, words 9,6
    s_se8 = '0; s_rdy8 = '0; s_cfge8 = '0; s_done8 = '0; h8 = '0; n8 = 0; nacc8 = 0;
    data8 = 4'h9; valid8 = 1'b1; start8 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      acc8 = rdy8 & valid8;
      @(posedge CLK); #1;
      start8 = 1'b0;
      if (acc8) begin
        nacc8++;
        data8 = 4'h6;
      end
      s_se8[c]   = se8;
      s_rdy8[c]  = rdy8;
      s_cfge8[c] = cfge8;
      s_done8[c] = done8;
      if (se8) begin
        if (n8 < 8) h8[n8] = head8;
        n8++;
      end
    end
    check("exact_shift_en", s_se8, 32'h000007BC);
    check("exact_ready", s_rdy8, 32'h00000042);
    check("exact_cfge", s_cfge8, 32'h00001800);
    check("exact_done", s_done8, 32'h00002000);
    check("exact_nacc", nacc8, 32'd2);
    check("exact_nshift", n8, 32'd8);
    check("exact_head_seq", {24'h0, h8}, 32'h00000069);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
